// File: rtl/game_time_tik_generator.sv
// One-second game tick generator: a prescaler gated by a run/pause/stop FSM that
// drives a fixed-width time_tik pulse, a wrapping seconds count and an optional timeout.
module game_time_tik_generator #(
  parameter int unsigned CLK_FREQ        = 25000000,
  parameter int unsigned TIK_HIGH_CYCLES = 4,
  parameter int unsigned MAX_SECONDS     = 999,
  parameter int unsigned TIME_LIMIT      = 0
) (
  input  logic       clock_25,
  input  logic       reset,
  input  logic       sync_reset,
  input  logic       start,
  input  logic       pause,
  input  logic       game_over,
  output logic       time_tik,
  output logic [9:0] seconds,
  output logic       timeout,
  output logic       running
);

  localparam int unsigned PW = $clog2(CLK_FREQ);
  localparam int unsigned WW = $clog2(TIK_HIGH_CYCLES + 1);
  localparam int unsigned SW = 10;

  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_FREQ - 1);
  localparam logic [WW-1:0] WIDTH_LOAD = WW'(TIK_HIGH_CYCLES - 1);
  localparam logic [SW-1:0] SEC_MAX    = SW'(MAX_SECONDS);
  localparam logic [SW-1:0] SEC_LIMIT  = SW'(TIME_LIMIT);
  localparam bit            LIMIT_EN   = (TIME_LIMIT != 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUNNING,
    S_PAUSED,
    S_STOPPED
  } state_e;

  state_e        state_q,   state_d;
  logic [PW-1:0] presc_q,   presc_d;
  logic [WW-1:0] width_q,   width_d;
  logic [SW-1:0] seconds_q, seconds_d;
  logic          tik_q,     tik_d;
  logic          timeout_q, timeout_d;
  logic          running_q, running_d;

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    width_d   = width_q;
    seconds_d = seconds_q;
    tik_d     = 1'b0;
    timeout_d = 1'b0;

    // An in-flight pulse finishes regardless of what the FSM does.
    if (width_q != '0) begin
      width_d = width_q - WW'(1);
      tik_d   = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        presc_d   = '0;
        seconds_d = '0;
        if (start) state_d = S_RUNNING;
      end
      S_RUNNING: begin
        if (game_over) begin
          state_d = S_STOPPED;
        end else if (pause) begin
          state_d = S_PAUSED;
        end else if (presc_q == PRESC_LAST) begin
          presc_d   = '0;
          seconds_d = (seconds_q == SEC_MAX) ? '0 : seconds_q + SW'(1);
          tik_d     = 1'b1;
          width_d   = WIDTH_LOAD;
          if (LIMIT_EN && (seconds_d == SEC_LIMIT)) begin
            timeout_d = 1'b1;
            state_d   = S_STOPPED;
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      S_PAUSED: begin
        if (game_over)   state_d = S_STOPPED;
        else if (!pause) state_d = S_RUNNING;
      end
      default: ;
    endcase

    // New-game clear overrides everything, including a pulse in progress.
    if (sync_reset) begin
      state_d   = S_IDLE;
      presc_d   = '0;
      width_d   = '0;
      seconds_d = '0;
      tik_d     = 1'b0;
      timeout_d = 1'b0;
    end

    running_d = (state_d == S_RUNNING);
  end

  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      width_q   <= '0;
      seconds_q <= '0;
      tik_q     <= 1'b0;
      timeout_q <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      width_q   <= width_d;
      seconds_q <= seconds_d;
      tik_q     <= tik_d;
      timeout_q <= timeout_d;
      running_q <= running_d;
    end
  end

  assign time_tik = tik_q;
  assign seconds  = seconds_q;
  assign timeout  = timeout_q;
  assign running  = running_q;

endmodule

// File: tb/tb_game_time_tik_generator.sv
// Bench for game_time_tik_generator: two instances (wrap at 3 / limit at 2 seconds)
// share stimulus and are checked every cycle against an event-level model.
module tb_game_time_tik_generator;

  localparam int unsigned CF = 10;
  localparam int unsigned TH = 3;

  logic       clk = 1'b0;
  logic       reset, sync_reset, start, pause, game_over;
  logic       tik_a, to_a, run_a, tik_b, to_b, run_b;
  logic [9:0] sec_a, sec_b;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Model: mode 0=idle 1=running 2=paused 3=stopped; tik high while cyc < tik_end.
  int m_mode[2], m_cnt[2], m_secs[2], m_tik_end[2];
  bit m_to[2];
  int max_s[2] = '{3, 999};
  int lim[2]   = '{0, 2};

  game_time_tik_generator #(
    .CLK_FREQ(CF), .TIK_HIGH_CYCLES(TH), .MAX_SECONDS(3), .TIME_LIMIT(0)
  ) dut_a (
    .clock_25(clk), .reset(reset), .sync_reset(sync_reset), .start(start),
    .pause(pause), .game_over(game_over), .time_tik(tik_a), .seconds(sec_a),
    .timeout(to_a), .running(run_a)
  );

  game_time_tik_generator #(
    .CLK_FREQ(CF), .TIK_HIGH_CYCLES(TH), .MAX_SECONDS(999), .TIME_LIMIT(2)
  ) dut_b (
    .clock_25(clk), .reset(reset), .sync_reset(sync_reset), .start(start),
    .pause(pause), .game_over(game_over), .time_tik(tik_b), .seconds(sec_b),
    .timeout(to_b), .running(run_b)
  );

  always #5 clk = ~clk;

  function automatic void model_clear();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0; m_cnt[i] = 0; m_secs[i] = 0; m_tik_end[i] = 0; m_to[i] = 1'b0;
    end
  endfunction

  function automatic void model_edge();
    for (int i = 0; i < 2; i++) begin
      m_to[i] = 1'b0;
      if (sync_reset) begin
        m_mode[i] = 0; m_cnt[i] = 0; m_secs[i] = 0; m_tik_end[i] = 0;
      end else begin
        case (m_mode[i])
          0: if (start) m_mode[i] = 1;
          1: begin
            if (game_over) m_mode[i] = 3;
            else if (pause) m_mode[i] = 2;
            else begin
              m_cnt[i]++;
              if (m_cnt[i] == int'(CF)) begin
                m_cnt[i]     = 0;
                m_secs[i]    = (m_secs[i] + 1) % (max_s[i] + 1);
                m_tik_end[i] = cyc + int'(TH);
                if (lim[i] != 0 && m_secs[i] == lim[i]) begin
                  m_to[i]   = 1'b1;
                  m_mode[i] = 3;
                end
              end
            end
          end
          2: begin
            if (game_over) m_mode[i] = 3;
            else if (!pause) m_mode[i] = 1;
          end
          default: ;
        endcase
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_all();
    chk("a_tik",     32'(tik_a), 32'(cyc < m_tik_end[0]));
    chk("a_seconds", 32'(sec_a), 32'(m_secs[0]));
    chk("a_timeout", 32'(to_a),  32'(m_to[0]));
    chk("a_running", 32'(run_a), 32'(m_mode[0] == 1));
    chk("b_tik",     32'(tik_b), 32'(cyc < m_tik_end[1]));
    chk("b_seconds", 32'(sec_b), 32'(m_secs[1]));
    chk("b_timeout", 32'(to_b),  32'(m_to[1]));
    chk("b_running", 32'(run_b), 32'(m_mode[1] == 1));
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    if (!reset) model_clear();
    else model_edge();
    #1;
    check_all();
  endtask

  initial begin
    int r;
    bit found;
    reset = 1'b1; sync_reset = 1'b0; start = 1'b0; pause = 1'b0; game_over = 1'b0;
    model_clear();
    #2 reset = 1'b0;
    #1 check_all();
    for (int k = 0; k < 3; k++) step();
    chk("rst_seconds", 32'(sec_a), 32'd0);
    chk("rst_running", 32'(run_a), 32'd0);

    // Basic run: ticks at edges 11/21/31/41, wrap 3->0 on dut_a, timeout at 2 on dut_b.
    reset = 1'b1; start = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      step();
      if (k == 1)  chk("run_from_1", 32'(run_a), 32'd1);
      if (k == 10) chk("no_tik_10", 32'(tik_a), 32'd0);
      if (k == 11) begin chk("tik_rise_11", 32'(tik_a), 32'd1); chk("sec_11", 32'(sec_a), 32'd1); end
      if (k == 13) chk("tik_high_13", 32'(tik_a), 32'd1);
      if (k == 14) chk("tik_fall_14", 32'(tik_a), 32'd0);
      if (k == 21) begin
        chk("sec_21", 32'(sec_a), 32'd2);
        chk("b_timeout_21", 32'(to_b), 32'd1);
        chk("b_sec_21", 32'(sec_b), 32'd2);
      end
      if (k == 22) begin chk("b_to_once", 32'(to_b), 32'd0); chk("b_stopped", 32'(run_b), 32'd0); end
      if (k == 23) chk("b_tik_full", 32'(tik_b), 32'd1);
      if (k == 31) chk("sec_31", 32'(sec_a), 32'd3);
      if (k == 35) chk("b_no_more_tik", 32'(tik_b), 32'd0);
      if (k == 41) begin chk("wrap_sec", 32'(sec_a), 32'd0); chk("wrap_no_to", 32'(to_a), 32'd0); end
    end

    // Pause at prescaler=5, hold 20 clocks, resume.
    step();
    pause = 1'b1;
    for (int k = 0; k < 20; k++) step();
    chk("pause_sec", 32'(sec_a), 32'd0);
    chk("pause_run", 32'(run_a), 32'd0);
    pause = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      step();
      if (j == 5) chk("resume_no_tik", 32'(tik_a), 32'd0);
      if (j == 6) begin chk("resume_tik", 32'(tik_a), 32'd1); chk("resume_sec", 32'(sec_a), 32'd1); end
    end

    // Game over on the cycle after a tik rises.
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      step();
      found = (cyc < m_tik_end[0]) && (cyc == m_tik_end[0] - int'(TH));
    end
    chk("tik_found_go", 32'(found), 32'd1);
    game_over = 1'b1;
    step();
    game_over = 1'b0;
    chk("go_run", 32'(run_a), 32'd0);
    step();
    chk("go_tik_third", 32'(tik_a), 32'd1);
    step();
    chk("go_tik_done", 32'(tik_a), 32'd0);
    for (int k = 0; k < 15; k++) step();
    chk("go_start_ignored", 32'(run_a), 32'd0);
    sync_reset = 1'b1;
    step();
    sync_reset = 1'b0;
    chk("sr_sec", 32'(sec_a), 32'd0);
    chk("sr_run", 32'(run_a), 32'd0);

    // Game over on the exact cycle dut_b would hit its limit.
    for (int k = 0; k < 20; k++) step();
    game_over = 1'b1;
    step();
    game_over = 1'b0;
    chk("limit_go_to", 32'(to_b), 32'd0);
    chk("limit_go_sec", 32'(sec_b), 32'd1);
    chk("limit_go_tik", 32'(tik_b), 32'd0);
    for (int k = 0; k < 5; k++) step();

    // Randomized control sequence.
    sync_reset = 1'b1;
    step();
    sync_reset = 1'b0;
    for (int k = 0; k < 400; k++) begin
      r          = int'($urandom_range(0, 99));
      start      = ($urandom_range(0, 3) != 0);
      if (r < 8) pause = ~pause;
      game_over  = (r == 99);
      sync_reset = (r == 97 || r == 98);
      step();
    end

    // Async reset while time_tik is high.
    sync_reset = 1'b1; pause = 1'b0; game_over = 1'b0; start = 1'b1;
    step();
    sync_reset = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      step();
      found = (cyc < m_tik_end[0]);
    end
    chk("tik_found_rst", 32'(found), 32'd1);
    #2 reset = 1'b0;
    #1 model_clear();
    check_all();
    chk("arst_tik", 32'(tik_a), 32'd0);
    chk("arst_run", 32'(run_a), 32'd0);
    step();
    #2 reset = 1'b1;
    for (int k = 0; k < 5; k++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
